// File: rtl/dummy_accelerator_issue_ctrl_pkg.sv
// Shared types and constants for the dummy accelerator issue/commit front-end.
// Also provides the decode helper for the dummy instruction.
package dummy_accelerator_issue_ctrl_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned X_ID_WIDTH  = 4;
   localparam int unsigned X_NUM_RS    = 2;
   localparam int unsigned IMM_WIDTH   = 12;
   localparam int unsigned ISSUE_DEPTH = 2;

   localparam logic [6:0] DUMMY_INSTR_OPCODE = 7'b1110111;
   localparam logic [2:0] DUMMY_INSTR_FUNC3  = 3'b000;

   typedef logic [IMM_WIDTH-1:0] CtlType;

   typedef struct packed {
      logic [X_ID_WIDTH-1:0] id;
      logic [4:0]            rd_idx;
   } TagType;

   typedef struct packed {
      CtlType            ctl;
      logic [XLEN-1:0]   rs1;
      logic [XLEN-1:0]   rs2;
      TagType            tag;
      logic              committed;
      logic              killed;
   } IssueEntryType;

   function automatic logic is_dummy_instr(input logic [31:0] instr);
      return (instr[6:0] == DUMMY_INSTR_OPCODE) && (instr[14:12] == DUMMY_INSTR_FUNC3);
   endfunction

endpackage

// File: rtl/dummy_accelerator_issue_ctrl_if.sv
// X-IF issue/commit channels plus the execution-stage handshake of the front-end.
// slave = the issue controller, master = the core / execution stage side.
interface dummy_accelerator_issue_ctrl_if;
   import dummy_accelerator_issue_ctrl_pkg::*;

   logic                               issue_valid_i;
   logic                               issue_ready_o;
   logic [31:0]                        issue_instr_i;
   logic [X_ID_WIDTH-1:0]              issue_id_i;
   logic [X_NUM_RS-1:0][XLEN-1:0]      issue_rs_i;
   logic [X_NUM_RS-1:0]                issue_rs_valid_i;
   logic                               issue_resp_accept_o;
   logic                               issue_resp_writeback_o;

   logic                               commit_valid_i;
   logic [X_ID_WIDTH-1:0]              commit_id_i;
   logic                               commit_kill_i;

   logic                               ex_valid_o;
   logic                               ex_ready_i;
   CtlType                             ex_ctl_o;
   logic [XLEN-1:0]                    ex_rs1_o;
   logic [XLEN-1:0]                    ex_rs2_o;
   TagType                             ex_tag_o;

   modport slave (
      input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
      output issue_ready_o, issue_resp_accept_o, issue_resp_writeback_o,
      input  commit_valid_i, commit_id_i, commit_kill_i,
      output ex_valid_o, ex_ctl_o, ex_rs1_o, ex_rs2_o, ex_tag_o,
      input  ex_ready_i
   );

   modport master (
      output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i, issue_rs_valid_i,
      input  issue_ready_o, issue_resp_accept_o, issue_resp_writeback_o,
      output commit_valid_i, commit_id_i, commit_kill_i,
      input  ex_valid_o, ex_ctl_o, ex_rs1_o, ex_rs2_o, ex_tag_o,
      output ex_ready_i
   );

endinterface

// File: rtl/dummy_accelerator_issue_ctrl.sv
// In-order issue buffer: accepts dummy instructions, tracks commit/kill per entry,
// and presents committed heads to the execution stage.
module dummy_accelerator_issue_ctrl
   import dummy_accelerator_issue_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = ISSUE_DEPTH
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   dummy_accelerator_issue_ctrl_if.slave      xif
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   IssueEntryType          entry_q [DEPTH];
   IssueEntryType          entry_d [DEPTH];
   logic [DEPTH-1:0]       vld_q, vld_d;
   logic [PW-1:0]          head_q, head_d;
   logic [PW-1:0]          tail_q, tail_d;
   logic [CW-1:0]          count_q, count_d;

   logic                   is_match;
   logic                   full;
   logic                   empty;
   logic                   rs_ok;
   logic                   push;
   logic                   pop;
   logic                   head_ok;
   IssueEntryType          head;
   IssueEntryType          new_entry;
   logic                   unused_instr_bits;

   assign unused_instr_bits = ^xif.issue_instr_i[19:15];

   assign is_match = is_dummy_instr(xif.issue_instr_i);
   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   assign rs_ok    = &xif.issue_rs_valid_i;

   // Ready depends only on the decoded instruction, operand flags and registered
   // occupancy, so a head pop in the same cycle cannot unblock a full buffer.
   assign xif.issue_ready_o          = is_match ? (!full && rs_ok) : 1'b1;
   assign xif.issue_resp_accept_o    = is_match;
   assign xif.issue_resp_writeback_o = is_match;

   assign push = xif.issue_valid_i && is_match && !full && rs_ok;

   assign head    = entry_q[head_q];
   assign head_ok = !empty && head.committed && !head.killed;
   assign pop     = !empty && (head.killed || (head.committed && xif.ex_ready_i));

   assign xif.ex_valid_o = head_ok;
   assign xif.ex_ctl_o   = head.ctl;
   assign xif.ex_rs1_o   = head.rs1;
   assign xif.ex_rs2_o   = head.rs2;
   assign xif.ex_tag_o   = head.tag;

   always_comb begin
      new_entry            = '0;
      new_entry.ctl        = xif.issue_instr_i[31:20];
      new_entry.rs1        = xif.issue_rs_i[0];
      new_entry.rs2        = xif.issue_rs_i[1];
      new_entry.tag.id     = xif.issue_id_i;
      new_entry.tag.rd_idx = xif.issue_instr_i[11:7];
      // A commit naming the instruction being issued right now lands on the new entry.
      if (xif.commit_valid_i && (xif.commit_id_i == xif.issue_id_i)) begin
         new_entry.committed = !xif.commit_kill_i;
         new_entry.killed    = xif.commit_kill_i;
      end
   end

   always_comb begin
      entry_d = entry_q;
      vld_d   = vld_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (xif.commit_valid_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (vld_q[i] && (entry_q[i].tag.id == xif.commit_id_i)) begin
               if (xif.commit_kill_i) entry_d[i].killed    = 1'b1;
               else                   entry_d[i].committed = 1'b1;
            end
         end
      end

      if (pop) begin
         vld_d[head_q] = 1'b0;
         head_d        = head_q + PW'(1);
      end

      if (push) begin
         entry_d[tail_q] = new_entry;
         vld_d[tail_q]   = 1'b1;
         tail_d          = tail_q + PW'(1);
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
         vld_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         entry_q <= entry_d;
         vld_q   <= vld_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

endmodule
